vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates the 640x480@60 raster for the display pipeline: pixel-rate clock, DrawX/DrawY coordinates, the active-high blank (display-enable) flag, and hsync/vsync.
- vs serves as frame_clk for the background scroller and sprite logic.
- Sync outputs are delayed by a parameterised number of pixels so they line up with the renderers' registered RGB output (ROM read plus output register).
- Sits between the 50 MHz system clock and the VGA DAC pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_DELAY, 1, pixel periods of delay applied to hs/vs/blank_d relative to DrawX/DrawY; legal range 0..4

Ports:
- Clk  in  1  50 MHz system clock; the only clock in the block
- Reset  in  1  synchronous, active-high reset
- vga_clk  out  1  pixel clock, Clk/2, registered toggle
- pix_en  out  1  one-Clk pulse marking the Clk cycle in which the counters advance
- DrawX  out  10  current horizontal count (0..H_TOTAL-1)
- DrawY  out  10  current vertical count (0..V_TOTAL-1)
- blank  out  1  1 = active video (DrawX<H_ACTIVE and DrawY<V_ACTIVE); undelayed, aligned to DrawX/DrawY
- blank_d  out  1  blank delayed by SYNC_DELAY pixels, used to gate the DAC
- hs  out  1  horizontal sync, active low, delayed by SYNC_DELAY
- vs  out  1  vertical sync, active low, delayed by SYNC_DELAY; used as frame_clk
- frame_tick  out  1  one-Clk pulse, asserted on the pix_en cycle in which DrawY wraps to 0
- line_tick  out  1  one-Clk pulse, asserted on the pix_en cycle in which DrawX wraps to 0

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525). Both must be at most 1024; assertion in simulation.
- Reset, synchronous, highest priority:
  - vga_clk=0, pix_en=0, DrawX=0, DrawY=0.
  - All delay-line stages cleared to the idle pattern (hs=1, vs=1, blank_d=0).
  - frame_tick=0, line_tick=0.
  - blank is combinational from the counters, so it reads 1 during reset.
- Pixel enable:
  - A toggle register flips every Clk; vga_clk is that register.
  - pix_en is high in the Clk cycle where the toggle is 1, so the counters update coincident with the vga_clk falling edge.
  - First pix_en occurs on the second Clk after Reset deasserts.
- Horizontal counter, on pix_en: if DrawX==H_TOTAL-1 then DrawX<=0, else DrawX+1.
- Vertical counter, on a pix_en where DrawX wraps: if DrawY==V_TOTAL-1 then DrawY<=0, else DrawY+1.
- Counters are unsigned 10-bit and never exceed TOTAL-1. Any out-of-range value is forced to 0 on the next pix_en.
- Raw sync, combinational from the counters:
  - hs_raw = 0 iff H_ACTIVE+H_FP <= DrawX < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
  - vs_raw = 0 iff V_ACTIVE+V_FP <= DrawY < V_ACTIVE+V_FP+V_SYNC (490..491).
- Delay line:
  - {hs_raw, vs_raw, blank} shift through SYNC_DELAY stages, advancing only on pix_en.
  - SYNC_DELAY=0 means outputs equal the raw values combinationally.
- Ticks:
  - line_tick and frame_tick are registered and high for exactly one Clk.
  - On the cycle where both wrap (end of frame), both are asserted together.
- Reset mid-frame: all state returns to the reset values on the next Clk. No partial-line or partial-frame recovery; the next frame starts at (0,0).

Decomposition:
- Package vga_timing_pkg:
  - localparams H_TOTAL and V_TOTAL, the sync start/end constants, and the defaults above.
  - typedef coord_t (logic [9:0]) shared with the background and sprite renderers.
- One natural sub-module, vga_sync_delay: a SYNC_DELAY-deep, pix_en-qualified shift register for the 3-bit {hs, vs, blank} bundle with reset to the idle pattern.

Test Plan:
- Reset held 4 Clk, then released -> DrawX=DrawY=0, hs=vs=1, blank_d=0; first pix_en on the 2nd Clk after release; vga_clk period exactly 2 Clk.
- Free run one line -> line_tick once per 800 pix_en; with SYNC_DELAY=0, hs low for exactly 96 pixels (DrawX 656..751); blank high for DrawX 0..639 on DrawY<480.
- Free run one frame -> frame_tick exactly once per 800*525=420000 pix_en, coincident with line_tick; vs low for lines 490..491 (2*800 pixels).
- SYNC_DELAY=1 -> hs falls on the pix_en after DrawX becomes 656; blank_d falls one pixel after blank falls at DrawX=640.
- Reset asserted at DrawX=300, DrawY=200 for 1 Clk -> next Clk shows DrawX=0, DrawY=0, ticks low; subsequent frame has full 420000-pixel length.
- Boundary: observe DrawX 799->0 and DrawY 524->0 -> no value 800 or 525 ever appears; frame_tick and line_tick both high on the same Clk.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared raster constants and types for the 640x480@60 display
// pipeline. Holds the default porch/sync geometry, the derived line/frame
// totals and sync windows, the coordinate type used by the renderers, and the
// idle pattern of the {hs, vs, blank} bundle.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_ACTIVE_DEF   = 640;
  localparam int H_FP_DEF       = 16;
  localparam int H_SYNC_DEF     = 96;
  localparam int H_BP_DEF       = 48;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int V_FP_DEF       = 10;
  localparam int V_SYNC_DEF     = 2;
  localparam int V_BP_DEF       = 33;
  localparam int SYNC_DELAY_DEF = 1;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

  // {hs, vs, blank}: syncs deasserted (high), video disabled.
  localparam logic [2:0] SYNC_IDLE = 3'b110;

  // True when lo <= v < hi.
  function automatic logic in_window(input int v, input int lo, input int hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: DEPTH-stage shift register for the {hs, vs, blank} bundle.
// Stages advance only when en is high (one step per pixel) and reset to the
// idle pattern. DEPTH = 0 passes din straight through.
// Ports: clk, reset (sync, active high), en (pixel advance), din[2:0], dout[2:0].
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [2:0] din,
  output logic [2:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ok;
      assign unused_ok = ^{clk, reset, en};
      assign dout = din;
    end else begin : g_shift
      logic [2:0] stage [DEPTH];

      // Pixel-qualified shift; stage[DEPTH-1] is the oldest sample.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= SYNC_IDLE;
        end else if (en) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster generator running from the 50 MHz clock.
// Ports: Clk, Reset (sync, active high) in; vga_clk (Clk/2), pix_en (counter
// advance strobe), DrawX/DrawY (raster position), blank (active video,
// undelayed), blank_d/hs/vs (delayed by SYNC_DELAY pixels, syncs active low),
// line_tick/frame_tick (one-Clk pulses on the pixel where X / X and Y wrap).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int SYNC_DELAY = SYNC_DELAY_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       vga_clk,
  output logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       blank_d,
  output logic       hs,
  output logic       vs,
  output logic       frame_tick,
  output logic       line_tick
);

  localparam int H_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_LEN    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic toggle;
  logic x_last;
  logic y_last;
  logic y_over;
  logic hs_raw;
  logic vs_raw;

  // vga_clk and pix_en are the same register: counters move on the Clk edge
  // that ends the toggle-high cycle, i.e. on the falling edge of vga_clk.
  assign vga_clk = toggle;
  assign pix_en  = toggle;

  // ">=" rather than "==" so a corrupted count still wraps to zero.
  assign x_last = int'(DrawX) >= H_LEN - 1;
  assign y_last = int'(DrawY) >= V_LEN - 1;
  assign y_over = int'(DrawY) >  V_LEN - 1;

  assign blank  = (int'(DrawX) < H_ACTIVE) && (int'(DrawY) < V_ACTIVE);
  assign hs_raw = ~in_window(int'(DrawX), HS_START, HS_END);
  assign vs_raw = ~in_window(int'(DrawY), VS_START, VS_END);

  // Pixel toggle, raster counters and wrap ticks.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      toggle     <= 1'b0;
      DrawX      <= 10'd0;
      DrawY      <= 10'd0;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      toggle <= ~toggle;
      // Ticks are loaded one edge early so they are high during the pix_en
      // cycle whose closing edge performs the wrap.
      line_tick  <= ~toggle & x_last;
      frame_tick <= ~toggle & x_last & y_last;
      if (toggle) begin
        if (x_last) begin
          DrawX <= 10'd0;
          if (y_last) DrawY <= 10'd0;
          else        DrawY <= DrawY + 10'd1;
        end else begin
          DrawX <= DrawX + 10'd1;
          if (y_over) DrawY <= 10'd0;
        end
      end
    end
  end

  vga_sync_delay #(
    .DEPTH (SYNC_DELAY)
  ) u_sync_delay (
    .clk   (Clk),
    .reset (Reset),
    .en    (pix_en),
    .din   ({hs_raw, vs_raw, blank}),
    .dout  ({hs, vs, blank_d})
  );

  // Geometry guard: counters are 10 bits wide and the delay line is short.
  always_ff @(posedge Clk) begin
    assert (H_LEN <= 1024 && V_LEN <= 1024 && SYNC_DELAY >= 0 && SYNC_DELAY <= 4)
      else $error("vga_timing_gen: illegal geometry or SYNC_DELAY");
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three instances (default geometry with SYNC_DELAY 1 and 0,
// and a small geometry with SYNC_DELAY 2 so whole frames fit in the run).
// The driver counts Clk edges since the last reset edge, derives expected
// outputs from that count with plain arithmetic, and queues them; a monitor
// on the falling edge pops and compares.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct packed {
    logic       vclk;
    logic       pen;
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       blank_d;
    logic       hs;
    logic       vs;
    logic       ftick;
    logic       ltick;
  } obs_t;

  typedef struct {
    int ha, hf, hsw, hb, va, vf, vsw, vb, d;
  } geom_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #10 Clk = ~Clk;

  logic       vclk_a, pen_a, blank_a, blank_d_a, hs_a, vs_a, ft_a, lt_a;
  logic [9:0] x_a, y_a;
  logic       vclk_b, pen_b, blank_b, blank_d_b, hs_b, vs_b, ft_b, lt_b;
  logic [9:0] x_b, y_b;
  logic       vclk_c, pen_c, blank_c, blank_d_c, hs_c, vs_c, ft_c, lt_c;
  logic [9:0] x_c, y_c;

  vga_timing_gen #(.SYNC_DELAY(1)) dut_a (
    .Clk(Clk), .Reset(Reset), .vga_clk(vclk_a), .pix_en(pen_a), .DrawX(x_a), .DrawY(y_a),
    .blank(blank_a), .blank_d(blank_d_a), .hs(hs_a), .vs(vs_a), .frame_tick(ft_a), .line_tick(lt_a));

  vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_DELAY(2)) dut_b (
    .Clk(Clk), .Reset(Reset), .vga_clk(vclk_b), .pix_en(pen_b), .DrawX(x_b), .DrawY(y_b),
    .blank(blank_b), .blank_d(blank_d_b), .hs(hs_b), .vs(vs_b), .frame_tick(ft_b), .line_tick(lt_b));

  vga_timing_gen #(.SYNC_DELAY(0)) dut_c (
    .Clk(Clk), .Reset(Reset), .vga_clk(vclk_c), .pix_en(pen_c), .DrawX(x_c), .DrawY(y_c),
    .blank(blank_c), .blank_d(blank_d_c), .hs(hs_c), .vs(vs_c), .frame_tick(ft_c), .line_tick(lt_c));

  geom_t ga = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
  geom_t gb = '{16, 2, 3, 3, 10, 1, 2, 2, 2};
  geom_t gc = '{640, 16, 96, 48, 480, 10, 2, 33, 0};

  obs_t qa[$];
  obs_t qb[$];
  obs_t qc[$];

  int checks = 0;
  int errors = 0;
  int n = 0;
  bit armed = 1'b0;

  // Expected outputs n Clk edges after the last reset edge: pixel p = n/2 has
  // been reached, position is p in row-major raster order, and the delayed
  // bundle shows the raster state of pixel p-d (idle before any such pixel).
  function automatic obs_t model(input geom_t g, input int cnt);
    obs_t o;
    int ht = g.ha + g.hf + g.hsw + g.hb;
    int vt = g.va + g.vf + g.vsw + g.vb;
    int p = cnt / 2;
    int x = p % ht;
    int y = (p / ht) % vt;
    int qx, qy;
    o.vclk  = (cnt % 2) == 1;
    o.pen   = o.vclk;
    o.x     = 10'(x);
    o.y     = 10'(y);
    o.blank = (x < g.ha) && (y < g.va);
    o.ltick = o.pen && (x == ht - 1);
    o.ftick = o.ltick && (y == vt - 1);
    if (p < g.d) begin
      o.hs = 1'b1;
      o.vs = 1'b1;
      o.blank_d = 1'b0;
    end else begin
      qx = (p - g.d) % ht;
      qy = ((p - g.d) / ht) % vt;
      o.hs = !(qx >= g.ha + g.hf && qx < g.ha + g.hf + g.hsw);
      o.vs = !(qy >= g.va + g.vf && qy < g.va + g.vf + g.vsw);
      o.blank_d = (qx < g.ha) && (qy < g.va);
    end
    return o;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cmp(input string nm, input obs_t a, input obs_t e);
    chk({nm, ".vga_clk"}, int'(a.vclk), int'(e.vclk));
    chk({nm, ".pix_en"}, int'(a.pen), int'(e.pen));
    chk({nm, ".DrawX"}, int'(a.x), int'(e.x));
    chk({nm, ".DrawY"}, int'(a.y), int'(e.y));
    chk({nm, ".blank"}, int'(a.blank), int'(e.blank));
    chk({nm, ".blank_d"}, int'(a.blank_d), int'(e.blank_d));
    chk({nm, ".hs"}, int'(a.hs), int'(e.hs));
    chk({nm, ".vs"}, int'(a.vs), int'(e.vs));
    chk({nm, ".frame_tick"}, int'(a.ftick), int'(e.ftick));
    chk({nm, ".line_tick"}, int'(a.ltick), int'(e.ltick));
  endtask

  // Drive Reset for the next edge, then queue the expected post-edge state.
  task automatic step(input bit r);
    Reset = r;
    @(posedge Clk);
    #1;
    if (r) begin
      n = 0;
      armed = 1'b1;
    end else begin
      n++;
    end
    if (armed) begin
      qa.push_back(model(ga, n));
      qb.push_back(model(gb, n));
      qc.push_back(model(gc, n));
    end
  endtask

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Monitor: compare one queued expectation per DUT on every falling edge.
  initial begin
    obs_t act;
    forever begin
      @(negedge Clk);
      if (qa.size() > 0) begin
        act = '{vclk_a, pen_a, x_a, y_a, blank_a, blank_d_a, hs_a, vs_a, ft_a, lt_a};
        cmp("dflt_d1", act, qa.pop_front());
      end
      if (qb.size() > 0) begin
        act = '{vclk_b, pen_b, x_b, y_b, blank_b, blank_d_b, hs_b, vs_b, ft_b, lt_b};
        cmp("small_d2", act, qb.pop_front());
      end
      if (qc.size() > 0) begin
        act = '{vclk_c, pen_c, x_c, y_c, blank_c, blank_d_c, hs_c, vs_c, ft_c, lt_c};
        cmp("dflt_d0", act, qc.pop_front());
      end
      if (errors > 40) finish_run();
    end
  end

  // Stimulus: directed reset/line/frame phases, then random runs and resets.
  initial begin
    int len;
    int rlen;
    repeat (4) step(1'b1);
    // Three-plus default lines: covers hsync, blank edges and line wraps.
    repeat (5000) step(1'b0);
    // Small geometry: reset one Clk at X=10, Y=5, then two full frames.
    step(1'b1);
    repeat (2 * (5 * 24 + 10)) step(1'b0);
    step(1'b1);
    repeat (2 * 360 * 2 + 10) step(1'b0);
    for (int i = 0; i < 12; i++) begin
      rlen = $urandom_range(1, 3);
      len  = $urandom_range(50, 4000);
      repeat (rlen) step(1'b1);
      repeat (len) step(1'b0);
    end
    @(negedge Clk);
    #2;
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    chk("drain_c", qc.size(), 0);
    finish_run();
  end

endmodule
